// File: rtl/soc_axi_mux4.sv
// soc_axi_mux4: four-master to one-slave AXI4 mux with round-robin AW/AR arbitration,
// 2-bit master-index ID extension and W routing in AW-grant order.
// Optional macro SOC_AXI_MUX_SPILL_EN adds one-entry spill registers on the slave AW/AR outputs.

package soc_axi_mux4_pkg;
    localparam int unsigned IdWidth    = 4;
    localparam int unsigned SlvIdWidth = IdWidth + 2;
    localparam int unsigned AddrWidth  = 32;
    localparam int unsigned DataWidth  = 64;
    localparam int unsigned UserWidth  = 1;

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
        logic [5:0]           atop;
        logic [UserWidth-1:0] user;
    } ax_attr_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        ax_attr_t           attr;
    } ax_chan_t;

    typedef struct packed {
        logic [SlvIdWidth-1:0] id;
        ax_attr_t              attr;
    } ax_slv_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0]   data;
        logic [DataWidth/8-1:0] strb;
        logic                   last;
        logic [UserWidth-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [1:0]           resp;
        logic [UserWidth-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [SlvIdWidth-1:0] id;
        logic [1:0]            resp;
        logic [UserWidth-1:0]  user;
    } b_slv_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
        logic [UserWidth-1:0] user;
    } r_chan_t;

    typedef struct packed {
        logic [SlvIdWidth-1:0] id;
        logic [DataWidth-1:0]  data;
        logic [1:0]            resp;
        logic                  last;
        logic [UserWidth-1:0]  user;
    } r_slv_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;

    typedef struct packed {
        ax_slv_chan_t aw;
        logic         aw_valid;
        w_chan_t      w;
        logic         w_valid;
        logic         b_ready;
        ax_slv_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } req_slv_t;

    typedef struct packed {
        logic        aw_ready;
        logic        ar_ready;
        logic        w_ready;
        logic        b_valid;
        b_slv_chan_t b;
        logic        r_valid;
        r_slv_chan_t r;
    } resp_slv_t;

    // Returns {found, index} of the first valid master at or after ptr.
    function automatic logic [2:0] rr_pick(input logic [3:0] valid, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = {1'b0, ptr};
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            res = valid[idx] ? {1'b1, idx} : res;
        end
        return res;
    endfunction

    function automatic ax_slv_chan_t ext_ax(input ax_chan_t ax, input logic [1:0] idx);
        ax_slv_chan_t res;
        res.id   = {idx, ax.id};
        res.attr = ax.attr;
        return res;
    endfunction
endpackage

module soc_axi_mux4_arb
    import soc_axi_mux4_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [3:0]         valid_i,
    input  ax_chan_t [3:0]     chan_i,
    input  logic               room_i,
    input  logic               slv_ready_i,
    output logic               slv_valid_o,
    output ax_slv_chan_t       slv_chan_o,
    output logic               hs_o,
    output logic [1:0]         sel_o
);
    logic [1:0] rr_q, rr_d;
    logic [2:0] pick_s;

    assign pick_s = rr_pick(valid_i, rr_q);

`ifdef SOC_AXI_MUX_SPILL_EN
    logic         spill_vld_q, spill_vld_d;
    ax_slv_chan_t spill_q, spill_d;

    // Accept from the master whenever the spill slot is empty or draining this cycle.
    always_comb begin
        sel_o       = pick_s[1:0];
        hs_o        = pick_s[2] && room_i && (!spill_vld_q || slv_ready_i);
        slv_valid_o = spill_vld_q;
        slv_chan_o  = spill_q;
        rr_d        = rr_q;
        spill_vld_d = spill_vld_q;
        spill_d     = spill_q;
        if (hs_o) begin
            rr_d        = sel_o + 2'd1;
            spill_vld_d = 1'b1;
            spill_d     = ext_ax(chan_i[sel_o], sel_o);
        end else if (slv_ready_i) begin
            spill_vld_d = 1'b0;
        end else begin
            spill_vld_d = spill_vld_q;
        end
    end

    // Pointer and spill register state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q        <= 2'd0;
            spill_vld_q <= 1'b0;
            spill_q     <= '0;
        end else begin
            rr_q        <= rr_d;
            spill_vld_q <= spill_vld_d;
            spill_q     <= spill_d;
        end
    end
`else
    logic       lock_q, lock_d;
    logic [1:0] idx_q, idx_d;

    // Selection freezes once offered to the slave so the request stays stable until accepted.
    always_comb begin
        sel_o       = lock_q ? idx_q : pick_s[1:0];
        slv_valid_o = valid_i[sel_o] && room_i;
        slv_chan_o  = ext_ax(chan_i[sel_o], sel_o);
        hs_o        = slv_valid_o && slv_ready_i;
        rr_d        = rr_q;
        lock_d      = lock_q;
        idx_d       = idx_q;
        if (hs_o) begin
            rr_d   = sel_o + 2'd1;
            lock_d = 1'b0;
        end else if (slv_valid_o) begin
            lock_d = 1'b1;
            idx_d  = sel_o;
        end else begin
            lock_d = lock_q;
        end
    end

    // Pointer and lock state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q   <= 2'd0;
            lock_q <= 1'b0;
            idx_q  <= 2'd0;
        end else begin
            rr_q   <= rr_d;
            lock_q <= lock_d;
            idx_q  <= idx_d;
        end
    end
`endif
endmodule

module soc_axi_mux4
    import soc_axi_mux4_pkg::*;
#(
    parameter int unsigned NumMst     = 4,
    parameter int unsigned WFifoDepth = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  req_t      [NumMst-1:0]  mst_req_i,
    output resp_t     [NumMst-1:0]  mst_resp_o,
    output req_slv_t                slv_req_o,
    input  resp_slv_t               slv_resp_i
);
    localparam int unsigned PtrW = $clog2(WFifoDepth);
    localparam logic [PtrW:0] FullCnt = (PtrW+1)'(WFifoDepth);

    logic [3:0]        aw_vld_s, ar_vld_s;
    ax_chan_t [3:0]    aw_chan_s, ar_chan_s;
    logic              aw_slv_valid_s, ar_slv_valid_s;
    ax_slv_chan_t      aw_slv_chan_s, ar_slv_chan_s;
    logic              aw_hs_s, ar_hs_s;
    logic [1:0]        aw_sel_s, ar_sel_s;
    logic              aw_room_s;

    logic [1:0]        fifo_q [WFifoDepth];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]     cnt_q, cnt_d;
    logic [1:0]        head_s;
    logic              w_act_s, w_pop_s;
    logic [1:0]        b_idx_s, r_idx_s;

    // Gather per-master address-channel requests.
    always_comb begin
        aw_vld_s  = 4'd0;
        ar_vld_s  = 4'd0;
        aw_chan_s = '0;
        ar_chan_s = '0;
        for (int i = 0; i < 4; i++) begin
            aw_vld_s[i]  = mst_req_i[i].aw_valid;
            ar_vld_s[i]  = mst_req_i[i].ar_valid;
            aw_chan_s[i] = mst_req_i[i].aw;
            ar_chan_s[i] = mst_req_i[i].ar;
        end
    end

    // A last-beat pop frees a slot in the same cycle, so a full FIFO still admits an AW then.
    always_comb begin
        head_s    = fifo_q[rd_ptr_q];
        w_act_s   = (cnt_q != '0);
        w_pop_s   = w_act_s && mst_req_i[head_s].w_valid && mst_req_i[head_s].w.last
                    && slv_resp_i.w_ready;
        aw_room_s = (cnt_q != FullCnt) || w_pop_s;
        b_idx_s   = slv_resp_i.b.id[IdWidth+1:IdWidth];
        r_idx_s   = slv_resp_i.r.id[IdWidth+1:IdWidth];
    end

    soc_axi_mux4_arb u_aw_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (aw_vld_s),
        .chan_i      (aw_chan_s),
        .room_i      (aw_room_s),
        .slv_ready_i (slv_resp_i.aw_ready),
        .slv_valid_o (aw_slv_valid_s),
        .slv_chan_o  (aw_slv_chan_s),
        .hs_o        (aw_hs_s),
        .sel_o       (aw_sel_s)
    );

    soc_axi_mux4_arb u_ar_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (ar_vld_s),
        .chan_i      (ar_chan_s),
        .room_i      (1'b1),
        .slv_ready_i (slv_resp_i.ar_ready),
        .slv_valid_o (ar_slv_valid_s),
        .slv_chan_o  (ar_slv_chan_s),
        .hs_o        (ar_hs_s),
        .sel_o       (ar_sel_s)
    );

    // W-route FIFO pointer and occupancy next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PtrW'(aw_hs_s);
        rd_ptr_d = rd_ptr_q + PtrW'(w_pop_s);
        cnt_d    = cnt_q + (PtrW+1)'(aw_hs_s) - (PtrW+1)'(w_pop_s);
    end

    // W-route FIFO storage of granted master indices.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < int'(WFifoDepth); i++) begin
                fifo_q[i] <= 2'd0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (aw_hs_s) begin
                fifo_q[wr_ptr_q] <= aw_sel_s;
            end
        end
    end

    // Output routing; everything is held quiet while reset is asserted.
    always_comb begin
        slv_req_o  = '0;
        mst_resp_o = '0;
        if (!rst_i) begin
            slv_req_o.aw       = aw_slv_chan_s;
            slv_req_o.aw_valid = aw_slv_valid_s;
            slv_req_o.ar       = ar_slv_chan_s;
            slv_req_o.ar_valid = ar_slv_valid_s;
            slv_req_o.w        = mst_req_i[head_s].w;
            slv_req_o.w_valid  = w_act_s && mst_req_i[head_s].w_valid;
            slv_req_o.b_ready  = mst_req_i[b_idx_s].b_ready;
            slv_req_o.r_ready  = mst_req_i[r_idx_s].r_ready;
            for (int i = 0; i < 4; i++) begin
                mst_resp_o[i].b.id   = slv_resp_i.b.id[IdWidth-1:0];
                mst_resp_o[i].b.resp = slv_resp_i.b.resp;
                mst_resp_o[i].b.user = slv_resp_i.b.user;
                mst_resp_o[i].r.id   = slv_resp_i.r.id[IdWidth-1:0];
                mst_resp_o[i].r.data = slv_resp_i.r.data;
                mst_resp_o[i].r.resp = slv_resp_i.r.resp;
                mst_resp_o[i].r.last = slv_resp_i.r.last;
                mst_resp_o[i].r.user = slv_resp_i.r.user;
            end
            mst_resp_o[aw_sel_s].aw_ready = aw_hs_s;
            mst_resp_o[ar_sel_s].ar_ready = ar_hs_s;
            mst_resp_o[head_s].w_ready    = w_act_s && slv_resp_i.w_ready;
            mst_resp_o[b_idx_s].b_valid   = slv_resp_i.b_valid;
            mst_resp_o[r_idx_s].r_valid   = slv_resp_i.r_valid;
        end else begin
            slv_req_o  = '0;
            mst_resp_o = '0;
        end
    end
endmodule
